sidnboard_seq: RTL and testbench
================================

Name: sidnboard_seq

Overview:
- Sequencer that consumes the sidnboard_rom init table and plays each (register, value) entry onto the SID chip's parallel write bus.
- Generates the SID phi2 clock and the SID reset pulse.
- Walks ROM addresses from 0 and issues one SID bus write per entry until it reads the sentinel entry (5'h1f / 8'hff) or passes address 255.
- Sits between sidnboard_rom and the SID pins.

Parameters:
- PHI2_HALF, 8, phi2 half-period in clk cycles (≥2).
- RESET_PHI2, 10, number of phi2 rising edges sid_rst_n is held low after start.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins SID reset plus table playback; honoured only in IDLE or DONE.
- rom_addr  out  8  ROM address; connects to sidnboard_rom addr.
- rom_read_en  out  1  ROM read strobe.
- rom_reg  in  5  ROM addr_out; valid the clk after rom_read_en.
- rom_val  in  8  ROM cmd_out; valid the clk after rom_read_en.
- sid_phi2  out  1  SID phi2 clock.
- sid_rst_n  out  1  SID reset, active low.
- sid_cs_n  out  1  SID chip select, active low.
- sid_rw  out  1  SID R/W; driven 0 only while a write is in progress.
- sid_addr  out  5  SID register address.
- sid_data  out  8  SID data bus (write only).
- busy  out  1  high from accepted start until DONE.
- done  out  1  high in DONE.
- write_count  out  9  number of SID writes completed since the last start.

Behaviour:
- Reset values (rst_n=0 at a clk edge, effective that edge, from any state):
  - rom_addr=0, rom_read_en=0, sid_phi2=0, sid_rst_n=0, sid_cs_n=1, sid_rw=1.
  - sid_addr=0, sid_data=0, busy=0, done=0, write_count=0.
  - phi2 divider cleared; state=IDLE.
- phi2 generation:
  - Free-running when not in reset; toggles every PHI2_HALF clk cycles.
  - Internal one-cycle pulses phi2_rise/phi2_fall mark the clk edge on which sid_phi2 goes 1/0.
- States:
  - IDLE: sid_rst_n held 0. On start, go to SRST and clear write_count.
  - SRST: count phi2_rise. On the RESET_PHI2-th rise, set sid_rst_n=1, rom_addr=0, go to FETCH.
  - FETCH: rom_read_en=1 for exactly one clk; go to WAIT.
  - WAIT: one clk for ROM latency; go to CHECK.
  - CHECK:
    - If rom_reg==5'h1f and rom_val==8'hff (sentinel), go to DONE; no bus cycle.
    - Otherwise latch sid_addr=rom_reg, sid_data=rom_val, sid_rw=0, and go to ARM.
  - ARM: wait for phi2_fall, then wait for the next phi2_rise. On that rise edge, sid_cs_n=0; go to STROBE. This guarantees sid_addr/sid_data are stable ≥PHI2_HALF clk before CS.
  - STROBE: on phi2_fall, go to HOLD (sid_cs_n stays 0 that edge).
  - HOLD: one clk later, sid_cs_n=1, sid_rw=1, write_count+1.
    - If rom_addr==8'hff, go to DONE (no wrap).
    - Else rom_addr+1, go to FETCH.
- CS_n pulse width: exactly PHI2_HALF+1 clk cycles (full phi2 high phase plus one clk hold).
- sid_addr/sid_data hold their value until the next CHECK load; they are never cleared between writes.
- DONE: done=1, busy=0; sid_rst_n stays 1; phi2 keeps running.
  - start in DONE clears done, restarts at SRST (SID is re-reset), and clears write_count.
- start in SRST..HOLD is ignored.
- busy=1 in SRST, FETCH, WAIT, CHECK, ARM, STROBE, HOLD.
- Simultaneous rst_n=0 and start: reset wins.
- Reset during STROBE: sid_cs_n=1 on that same edge; no write_count increment.

Test Plan:
- PHI2_HALF=4, RESET_PHI2=10, real sidnboard_rom: reset, pulse start.
  - sid_rst_n low until the 10th phi2 rise.
  - Exactly 6 CS pulses with (addr,data) = (18,04),(00,00),(01,20),(05,80),(06,f5),(04,11).
  - Then done=1, busy=0, write_count=6.
- Same setup, timing check on every write:
  - sid_cs_n low for exactly 5 clk, starting on a phi2 rising edge.
  - sid_rw=0 and sid_addr/sid_data stable ≥4 clk before CS falls and ≥1 clk after phi2 falls.
- Stub ROM returning 1f/ff at address 0: start -> no CS pulse, done=1, write_count=0, rom_read_en pulsed once.
- Start pulses while busy (during SRST and during STROBE) are ignored, with the sequence unchanged. Start in DONE clears done, re-asserts sid_rst_n for 10 phi2 rises, and replays all 6 writes.
- rst_n=0 during the 3rd write's STROBE:
  - Next edge: sid_cs_n=1, sid_rw=1, sid_phi2=0, write_count=0, state IDLE.
  - No further CS pulses until a new start.
- Stub ROM never returning the sentinel (always 00/00): 256 writes at rom_addr 0..255, then done=1, write_count=256, and no rom_addr wrap.

Source files
------------

// File: rtl/sidnboard_seq.sv
// Plays the sidnboard_rom (register, value) init table onto the SID parallel write bus.
// Also generates the SID phi2 clock and holds SID reset low for RESET_PHI2 phi2 rising edges after start.
module sidnboard_seq #(
  parameter int PHI2_HALF  = 8,
  parameter int RESET_PHI2 = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] rom_addr,
  output logic       rom_read_en,
  input  logic [4:0] rom_reg,
  input  logic [7:0] rom_val,
  output logic       sid_phi2,
  output logic       sid_rst_n,
  output logic       sid_cs_n,
  output logic       sid_rw,
  output logic [4:0] sid_addr,
  output logic [7:0] sid_data,
  output logic       busy,
  output logic       done,
  output logic [8:0] write_count
);

  localparam int DIV_W = (PHI2_HALF > 1) ? $clog2(PHI2_HALF) : 1;
  localparam int RC_W  = $clog2(RESET_PHI2 + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SRST, S_FETCH, S_WAIT, S_CHECK, S_ARM, S_STROBE, S_HOLD, S_DONE
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_divCnt;
  logic [RC_W-1:0]  r_rstCnt;
  logic             r_seenFall;
  logic             w_phi2Edge;
  logic             w_phi2Rise;
  logic             w_phi2Fall;
  logic             w_sentinel;

  // Rise/fall pulses are asserted on the same clk edge that flips sid_phi2.
  assign w_phi2Edge = (r_divCnt == DIV_W'(PHI2_HALF - 1));
  assign w_phi2Rise = w_phi2Edge & ~sid_phi2;
  assign w_phi2Fall = w_phi2Edge & sid_phi2;
  assign w_sentinel = (rom_reg == 5'h1f) && (rom_val == 8'hff);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_divCnt <= '0;
      sid_phi2 <= 1'b0;
    end else if (w_phi2Edge) begin
      r_divCnt <= '0;
      sid_phi2 <= ~sid_phi2;
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rstCnt    <= '0;
      r_seenFall  <= 1'b0;
      rom_addr    <= 8'd0;
      rom_read_en <= 1'b0;
      sid_rst_n   <= 1'b0;
      sid_cs_n    <= 1'b1;
      sid_rw      <= 1'b1;
      sid_addr    <= 5'd0;
      sid_data    <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      write_count <= 9'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          sid_rst_n <= 1'b0;
          if (start) begin
            r_state     <= S_SRST;
            r_rstCnt    <= '0;
            busy        <= 1'b1;
            write_count <= 9'd0;
          end
        end
        S_SRST: begin
          if (w_phi2Rise) begin
            if (r_rstCnt == RC_W'(RESET_PHI2 - 1)) begin
              sid_rst_n   <= 1'b1;
              rom_addr    <= 8'd0;
              rom_read_en <= 1'b1;
              r_state     <= S_FETCH;
            end else begin
              r_rstCnt <= r_rstCnt + 1'b1;
            end
          end
        end
        S_FETCH: begin
          rom_read_en <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: r_state <= S_CHECK;
        S_CHECK: begin
          if (w_sentinel) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            sid_addr   <= rom_reg;
            sid_data   <= rom_val;
            sid_rw     <= 1'b0;
            r_seenFall <= 1'b0;
            r_state    <= S_ARM;
          end
        end
        // Waiting for a fall first guarantees a full low phase of bus setup before CS.
        S_ARM: begin
          if (!r_seenFall) begin
            if (w_phi2Fall) r_seenFall <= 1'b1;
          end else if (w_phi2Rise) begin
            sid_cs_n <= 1'b0;
            r_state  <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (w_phi2Fall) r_state <= S_HOLD;
        end
        S_HOLD: begin
          sid_cs_n    <= 1'b1;
          sid_rw      <= 1'b1;
          write_count <= write_count + 1'b1;
          if (rom_addr == 8'hff) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            rom_addr    <= rom_addr + 1'b1;
            rom_read_en <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_DONE: begin
          if (start) begin
            r_state     <= S_SRST;
            r_rstCnt    <= '0;
            sid_rst_n   <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            write_count <= 9'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sidnboard_seq.sv
// Scoreboard bench for sidnboard_seq: a behavioural ROM plus a table-walk model feed an expected-write queue
// that a negedge monitor drains as SID chip-select pulses appear, while also checking bus timing.
module tb_sidnboard_seq;
  localparam int PHI2_HALF  = 4;
  localparam int RESET_PHI2 = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rom_addr;
  logic       rom_read_en;
  logic [4:0] rom_reg = 5'd0;
  logic [7:0] rom_val = 8'd0;
  logic       sid_phi2, sid_rst_n, sid_cs_n, sid_rw;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  logic       busy, done;
  logic [8:0] write_count;

  sidnboard_seq #(.PHI2_HALF(PHI2_HALF), .RESET_PHI2(RESET_PHI2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_read_en(rom_read_en), .rom_reg(rom_reg), .rom_val(rom_val),
    .sid_phi2(sid_phi2), .sid_rst_n(sid_rst_n), .sid_cs_n(sid_cs_n), .sid_rw(sid_rw),
    .sid_addr(sid_addr), .sid_data(sid_data), .busy(busy), .done(done), .write_count(write_count)
  );

  always #5 clk = ~clk;

  // Behavioural ROM contents, one-clk registered read like sidnboard_rom
  logic [4:0] romReg [256];
  logic [7:0] romVal [256];
  always @(posedge clk) begin
    if (rom_read_en) begin
      rom_reg <= romReg[rom_addr];
      rom_val <= romVal[rom_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  logic [12:0] expQ [$];
  int cyc = 0;
  int csFalls = 0;
  int reads = 0;
  int readIdx = 0;
  int phi2Rises = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor state
  logic        prevCs = 1'b1, prevPhi2 = 1'b0, prevBusy = 1'b0, prevRstN = 1'b0;
  logic [13:0] prevBus = '0;
  logic        csActive = 1'b0, rwBad = 1'b0;
  logic [12:0] capBus = '0;
  logic [12:0] expEntry;
  int          lastChangeCyc = 0, csFallCyc = 0, phi2FallCyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      csActive = 1'b0;
    end else begin
      if (prevBus != {sid_addr, sid_data, sid_rw}) lastChangeCyc = cyc;
      if (busy && !prevBusy) begin
        phi2Rises = 0;
        readIdx = 0;
      end
      if (prevBusy && !prevRstN && sid_phi2 && !prevPhi2) phi2Rises++;
      if (!prevRstN && sid_rst_n) checkOutput("rst_phi2_rises", phi2Rises, RESET_PHI2);
      if (rom_read_en) begin
        checkOutput("rom_read_addr", {24'd0, rom_addr}, readIdx);
        readIdx++;
        reads++;
      end
      if (prevCs && !sid_cs_n) begin
        csFalls++;
        csActive = 1'b1;
        csFallCyc = cyc;
        capBus = {sid_addr, sid_data};
        rwBad = 1'b0;
        phi2FallCyc = -100;
        checkOutput("cs_on_phi2_rise", {30'd0, prevPhi2, sid_phi2}, 32'd1);
        checkOutput("setup_ge_half", {31'd0, (cyc - lastChangeCyc) >= PHI2_HALF}, 32'd1);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write", 32'd0, 32'd1);
        end else begin
          expEntry = expQ.pop_front();
          checkOutput("write_addr_data", {19'd0, sid_addr, sid_data}, {19'd0, expEntry});
        end
      end
      if (!sid_cs_n && csActive) begin
        if (sid_rw !== 1'b0) rwBad = 1'b1;
        if (prevPhi2 && !sid_phi2) phi2FallCyc = cyc;
      end
      if (!prevCs && sid_cs_n && csActive) begin
        csActive = 1'b0;
        checkOutput("cs_low_width", cyc - csFallCyc, PHI2_HALF + 1);
        checkOutput("hold_after_fall", cyc - phi2FallCyc, 32'd1);
        checkOutput("rw_low_during_cs", {31'd0, rwBad}, 32'd0);
        checkOutput("bus_stable_cs", {19'd0, sid_addr, sid_data}, {19'd0, capBus});
      end
    end
    prevCs = sid_cs_n;
    prevPhi2 = sid_phi2;
    prevBusy = busy;
    prevRstN = sid_rst_n;
    prevBus = {sid_addr, sid_data, sid_rw};
  end

  // Reference model: walk the table from 0, stop at the sentinel or after address 255
  function automatic int modelLoad();
    int nReads = 0;
    for (int a = 0; a < 256; a++) begin
      nReads++;
      if (romReg[a] == 5'h1f && romVal[a] == 8'hff) return nReads;
      expQ.push_back({romReg[a], romVal[a]});
    end
    return nReads;
  endfunction

  task automatic fillRom(input int mode);
    int len;
    len = $urandom_range(0, 12);
    for (int a = 0; a < 256; a++) begin
      romReg[a] = 5'h00;
      romVal[a] = 8'h00;
      if (mode == 0 || mode == 1) begin
        romReg[a] = 5'h1f;
        romVal[a] = 8'hff;
      end else if (mode == 3) begin
        romReg[a] = 5'($urandom);
        romVal[a] = 8'($urandom);
        if (romReg[a] == 5'h1f && romVal[a] == 8'hff) romVal[a] = 8'hfe;
      end
    end
    if (mode == 0) begin
      romReg[0] = 5'h18; romVal[0] = 8'h04;
      romReg[1] = 5'h00; romVal[1] = 8'h00;
      romReg[2] = 5'h01; romVal[2] = 8'h20;
      romReg[3] = 5'h05; romVal[3] = 8'h80;
      romReg[4] = 5'h06; romVal[4] = 8'hf5;
      romReg[5] = 5'h04; romVal[5] = 8'h11;
    end else if (mode == 3) begin
      romReg[len] = 5'h1f;
      romVal[len] = 8'hff;
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic runToDone(input int expWrites, input int expReads, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_reached", {31'd0, done}, 32'd1);
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    checkOutput("write_count", {23'd0, write_count}, expWrites);
    checkOutput("rom_reads", reads, expReads);
    checkOutput("writes_pending", expQ.size(), 32'd0);
    checkOutput("sid_rst_n_done", {31'd0, sid_rst_n}, 32'd1);
    checkOutput("cs_idle_done", {31'd0, sid_cs_n}, 32'd1);
    expQ.delete();
  endtask

  int nW, nR, baseFalls, n;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    checkOutput("rst_read_en", {31'd0, rom_read_en}, 32'd0);
    checkOutput("rst_phi2", {31'd0, sid_phi2}, 32'd0);
    checkOutput("rst_sid_rst_n", {31'd0, sid_rst_n}, 32'd0);
    checkOutput("rst_cs_n", {31'd0, sid_cs_n}, 32'd1);
    checkOutput("rst_rw", {31'd0, sid_rw}, 32'd1);
    checkOutput("rst_bus", {19'd0, sid_addr, sid_data}, 32'd0);
    checkOutput("rst_busy_done", {30'd0, busy, done}, 32'd0);
    checkOutput("rst_write_count", {23'd0, write_count}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat ($urandom_range(3, 20)) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_sid_rst_n", {31'd0, sid_rst_n}, 32'd0);

    $display("[TB] real table playback");
    fillRom(0);
    nR = modelLoad(); nW = expQ.size();
    reads = 0;
    applyStimulus();
    runToDone(nW, nR, 1000);

    $display("[TB] starts while busy are ignored");
    nR = modelLoad(); nW = expQ.size();
    reads = 0;
    applyStimulus();
    @(negedge clk);
    checkOutput("restart_clears", {29'd0, done, busy, sid_rst_n}, 32'b010);
    checkOutput("restart_wc", {23'd0, write_count}, 32'd0);
    repeat ($urandom_range(5, 30)) @(posedge clk);
    applyStimulus();
    n = 0;
    while (sid_cs_n && n < 1000) begin @(negedge clk); n++; end
    checkOutput("first_cs_seen", {31'd0, sid_cs_n}, 32'd0);
    applyStimulus();
    runToDone(nW, nR, 1000);

    $display("[TB] sentinel at address 0");
    fillRom(1);
    nR = modelLoad(); nW = expQ.size();
    reads = 0;
    baseFalls = csFalls;
    applyStimulus();
    runToDone(nW, nR, 1000);
    checkOutput("no_cs_on_sentinel", csFalls - baseFalls, 32'd0);

    $display("[TB] reset during third write");
    fillRom(0);
    nR = modelLoad();
    baseFalls = csFalls;
    applyStimulus();
    n = 0;
    while (csFalls < baseFalls + 3 && n < 1000) begin @(negedge clk); n++; end
    checkOutput("third_cs_seen", csFalls - baseFalls, 32'd3);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_cs_rw", {30'd0, sid_cs_n, sid_rw}, 32'b11);
    checkOutput("abort_phi2", {31'd0, sid_phi2}, 32'd0);
    checkOutput("abort_wc", {23'd0, write_count}, 32'd0);
    checkOutput("abort_state", {29'd0, busy, done, sid_rst_n}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    expQ.delete();
    baseFalls = csFalls;
    repeat (150) @(negedge clk);
    checkOutput("no_cs_after_abort", csFalls - baseFalls, 32'd0);
    checkOutput("idle_after_abort", {30'd0, busy, done}, 32'd0);

    $display("[TB] table without sentinel");
    fillRom(2);
    nR = modelLoad(); nW = expQ.size();
    reads = 0;
    applyStimulus();
    runToDone(nW, nR, 20000);
    checkOutput("no_addr_wrap", {24'd0, rom_addr}, 32'hff);

    $display("[TB] random tables");
    for (int t = 0; t < 4; t++) begin
      fillRom(3);
      nR = modelLoad(); nW = expQ.size();
      reads = 0;
      repeat ($urandom_range(0, 9)) @(posedge clk);
      applyStimulus();
      runToDone(nW, nR, 2000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
